// File: rtl/axi_wr_burst_master_if.sv
// AXI4 write-address, write-data and write-response channel bundle used by
// axi_wr_burst_master. The master modport is the design side, slave the responder side.
interface axi_wr_burst_master_if #(
    parameter int unsigned ADDR_WIDTH = 27,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ID_WIDTH   = 4
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   axi_awid;
    logic [ADDR_WIDTH-1:0] axi_awaddr;
    logic [7:0]            axi_awlen;
    logic [2:0]            axi_awsize;
    logic [1:0]            axi_awburst;
    logic                  axi_awvalid;
    logic                  axi_awready;

    logic [DATA_WIDTH-1:0] axi_wdata;
    logic [BYTES-1:0]      axi_wstrb;
    logic                  axi_wlast;
    logic                  axi_wvalid;
    logic                  axi_wready;

    logic [ID_WIDTH-1:0]   axi_bid;
    logic [1:0]            axi_bresp;
    logic                  axi_bvalid;
    logic                  axi_bready;

    modport master (
        output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        input  axi_wready,
        input  axi_bid, axi_bresp, axi_bvalid,
        output axi_bready
    );

    modport slave (
        input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        output axi_wready,
        output axi_bid, axi_bresp, axi_bvalid,
        input  axi_bready
    );
endinterface

// File: rtl/axi_wr_burst_master.sv
// AXI4 write master: splits one user write request into INCR bursts bounded by
// MAX_BURST beats and a BOUNDARY_BYTES address boundary, one burst in flight.
module axi_wr_burst_master #(
    parameter int unsigned ADDR_WIDTH     = 27,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned AXI_ID         = 0,
    parameter int unsigned MAX_BURST      = 16,
    parameter int unsigned BOUNDARY_BYTES = 4096,
    parameter int unsigned LEN_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_data_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    axi_wr_burst_master_if.master axi
);
    localparam int unsigned BYTES  = DATA_WIDTH / 8;
    localparam int unsigned SIZE   = $clog2(BYTES);
    localparam int unsigned OFF_W  = $clog2(BOUNDARY_BYTES);
    localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [2:0] {IDLE, CALC, AW, W, B, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [BEAT_W-1:0]     beats_q, beats_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  err_flag_q, err_flag_d;
    logic                  awvalid_q, awvalid_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [7:0]            awlen_q, awlen_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic                  req_ready_q, req_ready_d;

    logic [31:0]           room_c;
    logic [31:0]           lim_c;
    logic                  bad_c;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            beats_q     <= '0;
            cnt_q       <= '0;
            err_flag_q  <= 1'b0;
            awvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            beats_q     <= beats_d;
            cnt_q       <= cnt_d;
            err_flag_q  <= err_flag_d;
            awvalid_q   <= awvalid_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        beats_d    = beats_q;
        cnt_d      = cnt_q;
        err_flag_d = err_flag_q;
        awvalid_d  = awvalid_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        // Burst size: min of remaining beats, MAX_BURST and beats left before the boundary
        room_c = (32'(BOUNDARY_BYTES) - 32'(addr_q[OFF_W-1:0])) >> SIZE;
        lim_c  = (32'(rem_q) < 32'(MAX_BURST)) ? 32'(rem_q) : 32'(MAX_BURST);
        if (room_c < lim_c) begin
            lim_c = room_c;
        end
        bad_c = (axi.axi_bresp != 2'b00) || (axi.axi_bid != ID_WIDTH'(AXI_ID));

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr & ~ADDR_WIDTH'(BYTES - 1);
                    rem_d      = req_len;
                    err_flag_d = 1'b0;
                    if (req_len == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                beats_d   = BEAT_W'(lim_c);
                awaddr_d  = addr_q;
                awlen_d   = 8'(lim_c - 32'd1);
                awvalid_d = 1'b1;
                state_d   = AW;
            end
            AW: begin
                if (axi.axi_awready) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    cnt_d     = awlen_q;
                    state_d   = W;
                end
            end
            W: begin
                if (axi.axi_wready) begin
                    if (cnt_q == 8'd0) begin
                        wvalid_d = 1'b0;
                        bready_d = 1'b1;
                        state_d  = B;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            B: begin
                if (axi.axi_bvalid) begin
                    bready_d   = 1'b0;
                    err_flag_d = err_flag_q | bad_c;
                    addr_d     = addr_q + (ADDR_WIDTH'(beats_q) << SIZE);
                    rem_d      = rem_q - LEN_WIDTH'(beats_q);
                    if (rem_d == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = err_flag_d;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    // Pop strobe follows the live W handshake so the show-ahead source advances in step
    assign wr_data_en = wvalid_q & axi.axi_wready;

    assign axi.axi_awid    = ID_WIDTH'(AXI_ID);
    assign axi.axi_awaddr  = awaddr_q;
    assign axi.axi_awlen   = awlen_q;
    assign axi.axi_awsize  = 3'(SIZE);
    assign axi.axi_awburst = 2'b01;
    assign axi.axi_awvalid = awvalid_q;
    assign axi.axi_wdata   = wr_data;
    assign axi.axi_wstrb   = '1;
    assign axi.axi_wlast   = wvalid_q & (cnt_q == 8'd0);
    assign axi.axi_wvalid  = wvalid_q;
    assign axi.axi_bready  = bready_q;
endmodule

// File: tb/tb_axi_wr_burst_master.sv
// Directed bench for axi_wr_burst_master: AXI slave responders plus a scoreboard of
// expected bursts, data beats and wlast flags.
module tb_axi_wr_burst_master;
    localparam int unsigned AW_W = 27;
    localparam int unsigned DW   = 16;
    localparam int unsigned IW   = 4;
    localparam int unsigned LW   = 16;

    logic            clk       = 1'b0;
    logic            rstn      = 1'b0;
    logic            req_valid = 1'b0;
    logic [AW_W-1:0] req_addr  = '0;
    logic [LW-1:0]   req_len   = '0;
    logic [DW-1:0]   wr_data   = '0;
    logic            req_ready, wr_data_en, busy, done, err;

    axi_wr_burst_master_if #(.ADDR_WIDTH(AW_W), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi_if ();

    axi_wr_burst_master #(
        .ADDR_WIDTH(AW_W), .DATA_WIDTH(DW), .ID_WIDTH(IW), .AXI_ID(0),
        .MAX_BURST(16), .BOUNDARY_BYTES(4096), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .wr_data(wr_data),
        .wr_data_en(wr_data_en), .busy(busy), .done(done), .err(err), .axi(axi_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] exp_aw[$], obs_aw[$];
    logic [DW-1:0] src_q[$], exp_data[$], obs_data[$];
    logic exp_last[$], obs_last[$];
    int pops         = 0;
    int aw_delay     = 0;
    bit wtoggle      = 1'b0;
    int err_burst    = -1;
    int bidx         = 0;
    int first_aw_cyc = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic exp_burst(input logic [AW_W-1:0] a, input int len_m1);
        exp_aw.push_back(64'({a, 8'(len_m1)}));
        for (int i = 0; i <= len_m1; i++) exp_last.push_back(i == len_m1);
    endtask

    // AW responder: optional acceptance delay, stability check while waiting
    initial begin
        int cnt;
        logic [AW_W-1:0] held_a;
        logic [7:0] held_l;
        cnt = 0; held_a = '0; held_l = '0;
        axi_if.axi_awready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                axi_if.axi_awready = 1'b0;
                cnt = 0;
            end else if (axi_if.axi_awready) begin
                axi_if.axi_awready = 1'b0;
            end else if (axi_if.axi_awvalid) begin
                if (cnt == 0) begin
                    held_a = axi_if.axi_awaddr;
                    held_l = axi_if.axi_awlen;
                    if (obs_aw.size() == 0 && first_aw_cyc < 0) first_aw_cyc = cyc;
                end else begin
                    chk("aw_addr_stable", 64'(axi_if.axi_awaddr), 64'(held_a));
                    chk("aw_len_stable", 64'(axi_if.axi_awlen), 64'(held_l));
                end
                if (cnt >= aw_delay) begin
                    obs_aw.push_back(64'({axi_if.axi_awaddr, axi_if.axi_awlen}));
                    chk("awsize", 64'(axi_if.axi_awsize), 64'd1);
                    chk("awburst", 64'(axi_if.axi_awburst), 64'd1);
                    chk("awid", 64'(axi_if.axi_awid), 64'd0);
                    axi_if.axi_awready = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // W responder and show-ahead data source
    initial begin
        bit pend;
        pend = 1'b0;
        axi_if.axi_wready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                axi_if.axi_wready = 1'b0;
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (src_q.size() != 0) void'(src_q.pop_front());
                    pend = 1'b0;
                end
                wr_data = (src_q.size() != 0) ? src_q[0] : '0;
                axi_if.axi_wready = wtoggle ? ~axi_if.axi_wready : 1'b1;
                #2;
                if (axi_if.axi_wvalid && axi_if.axi_wready) begin
                    obs_data.push_back(axi_if.axi_wdata);
                    obs_last.push_back(axi_if.axi_wlast);
                    pend = 1'b1;
                end
                if (wr_data_en) pops++;
            end
        end
    end

    // B responder: one cycle after bready, optional error on a chosen burst
    initial begin
        axi_if.axi_bvalid = 1'b0;
        axi_if.axi_bresp  = 2'b00;
        axi_if.axi_bid    = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                axi_if.axi_bvalid = 1'b0;
            end else if (axi_if.axi_bvalid) begin
                axi_if.axi_bvalid = 1'b0;
                bidx++;
            end else if (axi_if.axi_bready) begin
                axi_if.axi_bvalid = 1'b1;
                axi_if.axi_bresp  = (bidx == err_burst) ? 2'b10 : 2'b00;
                axi_if.axi_bid    = '0;
            end
        end
    end

    task automatic run_req(input string tag, input logic [AW_W-1:0] addr, input int len,
                           input bit exp_err);
        int rc;
        int waited;
        logic [DW-1:0] d;
        logic [63:0] o;
        for (int i = 0; i < len; i++) begin
            d = DW'($urandom);
            src_q.push_back(d);
            exp_data.push_back(d);
        end
        bidx = 0;
        first_aw_cyc = -1;
        @(negedge clk);
        req_valid = 1'b1; req_addr = addr; req_len = LW'(len); rc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        waited = 1;
        while (done !== 1'b1 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_err"}, 64'(err), 64'(exp_err));
        if (len == 0) chk({tag, "_done_lat"}, 64'(cyc - rc), 64'd1);
        else          chk({tag, "_aw_lat"}, 64'(first_aw_cyc - rc), 64'd2);
        chk({tag, "_aw_count"}, 64'(obs_aw.size()), 64'(exp_aw.size()));
        while (exp_aw.size() != 0) begin
            o = (obs_aw.size() != 0) ? obs_aw.pop_front() : 'x;
            chk({tag, "_aw"}, o, exp_aw.pop_front());
        end
        chk({tag, "_beats"}, 64'(obs_data.size()), 64'(exp_data.size()));
        while (exp_data.size() != 0) begin
            o = (obs_data.size() != 0) ? 64'(obs_data.pop_front()) : 'x;
            chk({tag, "_wdata"}, o, 64'(exp_data.pop_front()));
        end
        while (exp_last.size() != 0) begin
            o = (obs_last.size() != 0) ? 64'(obs_last.pop_front()) : 'x;
            chk({tag, "_wlast"}, o, 64'(exp_last.pop_front()));
        end
        chk({tag, "_pops"}, 64'(pops), 64'(len));
        obs_aw.delete(); obs_data.delete(); obs_last.delete();
        pops = 0;
        @(negedge clk);
        chk({tag, "_idle"}, 64'({busy, req_ready, done}), 64'b010);
    endtask

    initial begin
        int w;
        repeat (3) @(negedge clk);
        chk("rst_outputs", 64'({axi_if.axi_awvalid, axi_if.axi_wvalid, axi_if.axi_bready,
                                done, err, wr_data_en, busy}), 64'd0);
        chk("rst_awaddr", 64'(axi_if.axi_awaddr), 64'd0);
        chk("rst_awlen", 64'(axi_if.axi_awlen), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);

        exp_burst(27'h000, 7);
        run_req("single", 27'h000, 8, 1'b0);

        exp_burst(27'h000, 15); exp_burst(27'h020, 15); exp_burst(27'h040, 7);
        run_req("split40", 27'h000, 40, 1'b0);

        exp_burst(27'hFF8, 3); exp_burst(27'h1000, 5);
        run_req("boundary", 27'hFF8, 10, 1'b0);

        exp_burst(27'h7FF_FFFC, 1); exp_burst(27'h000_0000, 1);
        run_req("wrap", 27'h7FF_FFFD, 4, 1'b0);

        aw_delay = 5; wtoggle = 1'b1;
        exp_burst(27'h100, 7);
        run_req("slow", 27'h100, 8, 1'b0);
        aw_delay = 0; wtoggle = 1'b0;

        err_burst = 1;
        exp_burst(27'h200, 15); exp_burst(27'h220, 15); exp_burst(27'h240, 7);
        run_req("bresp_err", 27'h200, 40, 1'b1);
        err_burst = -1;
        exp_burst(27'h300, 4);
        run_req("clean_after_err", 27'h300, 5, 1'b0);

        run_req("len0", 27'h400, 0, 1'b0);

        // Reset in the middle of a W phase
        for (int i = 0; i < 40; i++) src_q.push_back(DW'(i));
        @(negedge clk);
        req_valid = 1'b1; req_addr = 27'h500; req_len = LW'(40);
        @(negedge clk);
        req_valid = 1'b0;
        w = 0;
        while (axi_if.axi_wvalid !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("midw_wvalid_seen", 64'(axi_if.axi_wvalid), 64'd1);
        rstn = 1'b0;
        @(negedge clk);
        chk("midw_rst_outputs", 64'({axi_if.axi_awvalid, axi_if.axi_wvalid, axi_if.axi_bready,
                                     done, err, wr_data_en, busy}), 64'd0);
        chk("midw_rst_aw", 64'({axi_if.axi_awaddr, axi_if.axi_awlen}), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        src_q.delete(); exp_data.delete(); exp_last.delete(); exp_aw.delete();
        obs_aw.delete(); obs_data.delete(); obs_last.delete();
        pops = 0;
        chk("midw_release", 64'({req_ready, busy}), 64'b10);

        exp_burst(27'h600, 2);
        run_req("after_reset", 27'h600, 3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
